bank_burst_engine: RTL and testbench

BANK_BURST_ENGINE -- requirements
Module: bank_burst_engine

---
 rtl/bank_burst_engine.sv | 111 +++++++++++
 tb/tb_bank_burst_engine.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/bank_burst_engine.sv
// bank_burst_engine: single-bank burst engine with an ACT/PRE/RD/WR command FSM and wrapped bursts.
// Optional feature macro: BANK_AUTOPRE_EN makes every read/write burst close the row on completion.
module bank_burst_engine #(
    parameter int DEVICE_WIDTH = 4,
    parameter int ROWS         = 131072,
    parameter int COLS         = 1024,
    parameter int BL           = 8,
    parameter int CL           = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd,
    input  logic [$clog2(ROWS)-1:0]   row,
    input  logic [$clog2(COLS)-1:0]   column,
    input  logic [DEVICE_WIDTH-1:0]   dqin,
    output logic [DEVICE_WIDTH-1:0]   dqout,
    output logic                      dq_valid,
    output logic                      row_open,
    output logic                      err
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int LB = $clog2(BL);
    localparam int AW = $clog2(ROWS * COLS);
    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] C_ACT = 3'd1;
    localparam logic [2:0] C_PRE = 3'd2;
    localparam logic [2:0] C_RD  = 3'd3;
    localparam logic [2:0] C_WR  = 3'd4;

    typedef enum logic [2:0] {S_IDLE, S_ACTIVE, S_WBURST, S_RWAIT, S_RBURST} state_t;

`ifdef BANK_AUTOPRE_EN
    localparam state_t S_DONE = S_IDLE;
`else
    localparam state_t S_DONE = S_ACTIVE;
`endif

    state_t                  r_state, w_next;
    logic [RW-1:0]           r_row;
    logic [CW-1:0]           r_col, w_col;
    logic [LB-1:0]           r_cnt;
    logic [3:0]              r_lat;
    logic                    r_err, w_err;
    logic                    w_acc, w_last, w_row_ok;
    logic [AW-1:0]           w_addr;
    logic [DEVICE_WIDTH-1:0] r_mem [ROWS*COLS];

    assign w_acc     = cmd_valid && cmd_ready;
    assign w_last    = r_cnt == LB'(BL - 1);
    assign w_row_ok  = 32'(row) < ROWS;
    assign w_addr    = AW'(r_row * COLS + 32'(w_col));
    assign cmd_ready = (r_state == S_IDLE) || (r_state == S_ACTIVE);
    assign row_open  = r_state != S_IDLE;
    assign dq_valid  = r_state == S_RBURST;
    assign dqout     = dq_valid ? r_mem[w_addr] : '0;
    assign err       = r_err;

    // Beat column: keep the block-select bits, wrap the low bits within the BL-aligned block
    always_comb begin
        w_col         = r_col;
        w_col[LB-1:0] = r_col[LB-1:0] + r_cnt;
    end

    // Next-state decode and illegal-command detection
    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        case (r_state)
            S_IDLE: if (w_acc) begin
                if (cmd == C_ACT && w_row_ok) w_next = S_ACTIVE;
                else if (cmd != C_NOP && cmd != C_PRE) w_err = 1'b1;
            end
            S_ACTIVE: if (w_acc) begin
                if (cmd == C_PRE) w_next = S_IDLE;
                else if (cmd == C_WR) w_next = S_WBURST;
                else if (cmd == C_RD) w_next = (CL == 1) ? S_RBURST : S_RWAIT;
                else if (cmd != C_NOP) w_err = 1'b1;
            end
            S_WBURST, S_RBURST: if (w_last) w_next = S_DONE;
            S_RWAIT: if (r_lat == 4'(CL - 1)) w_next = S_RBURST;
            default: w_next = S_IDLE;
        endcase
    end

    // State, latched addresses, beat/latency counters and the err pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_cnt   <= '0;
            r_lat   <= 4'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_err   <= w_err;
            r_row   <= (r_state == S_IDLE && w_next == S_ACTIVE) ? row : r_row;
            r_col   <= (r_state == S_ACTIVE && w_acc) ? column : r_col;
            r_cnt   <= (r_state == S_WBURST || r_state == S_RBURST) ? r_cnt + 1'b1 : '0;
            r_lat   <= (r_state == S_RWAIT) ? r_lat + 4'd1 : 4'd0;
        end
    end

    // Storage is written one beat per write-burst cycle and is never cleared by reset
    always_ff @(posedge clk) begin
        if (r_state == S_WBURST) r_mem[w_addr] <= dqin;
    end
endmodule

// File: tb/tb_bank_burst_engine.sv
// tb_bank_burst_engine: directed stimulus with a queue-based scoreboard for read beats and err pulses.
module tb_bank_burst_engine;
    localparam int DW = 4, ROWS = 12, COLS = 16, BL = 8, CL = 3;
`ifdef BANK_AUTOPRE_EN
    localparam bit AP = 1'b1;
`else
    localparam bit AP = 1'b0;
`endif

    logic          clk = 1'b0, rst_n = 1'b1, cmd_valid = 1'b0;
    logic [2:0]    cmd = 3'd0;
    logic [3:0]    row = 4'd0, column = 4'd0;
    logic [DW-1:0] dqin = '0;
    logic [DW-1:0] dqout;
    logic          cmd_ready, dq_valid, row_open, err;

    typedef struct {
        logic [3:0] d;
        int         c;
    } beat_t;

    beat_t bq[$];
    int    eq[$];
    int    cyc = 0, checks = 0, errors = 0;

    bank_burst_engine #(.DEVICE_WIDTH(DW), .ROWS(ROWS), .COLS(COLS), .BL(BL), .CL(CL)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd),
        .row(row), .column(column), .dqin(dqin), .dqout(dqout), .dq_valid(dq_valid),
        .row_open(row_open), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", n, a, e, cyc);
        end
    endtask

    // Drive one command for one cycle; an expected err pulse is queued for the cycle after acceptance
    task automatic issue(input logic [2:0] c, input logic [3:0] r, input logic [3:0] col, input bit e, output int acc);
        cmd_valid = 1'b1;
        cmd = c;
        row = r;
        column = col;
        chk("ready_at_issue", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
        acc = cyc;
        cmd_valid = 1'b0;
        cmd = 3'd0;
        if (e) eq.push_back(acc);
    endtask

    task automatic wr(input logic [3:0] col, input logic [31:0] p);
        int a;
        issue(3'd4, 4'd0, col, 1'b0, a);
        for (int k = 0; k < BL; k++) begin
            dqin = p[4*k +: 4];
            chk("ready_in_write", 32'(cmd_ready), 0);
            @(posedge clk);
            #1;
        end
        dqin = '0;
    endtask

    // Queue nb expected beats (pattern nibble k is beat k) and wait until just past beat nb-1
    task automatic rd(input logic [3:0] col, input logic [31:0] p, input int nb);
        int a;
        beat_t b;
        issue(3'd3, 4'd0, col, 1'b0, a);
        for (int k = 0; k < nb; k++) begin
            b.d = p[4*k +: 4];
            b.c = a + CL + k;
            bq.push_back(b);
        end
        repeat (CL + nb) @(posedge clk);
        #1;
    endtask

    // Monitor: every presented beat and err pulse must match the head of its queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (dq_valid) begin
                chk("beat_pending", 32'(bq.size() > 0), 1);
                if (bq.size() > 0) begin
                    beat_t b;
                    b = bq.pop_front();
                    chk("beat_data", 32'(dqout), 32'(b.d));
                    chk("beat_cycle", cyc, b.c);
                end
                chk("ready_in_read", 32'(cmd_ready), 0);
            end else begin
                chk("dqout_idle_zero", 32'(dqout), 0);
            end
            if (err) begin
                chk("err_pending", 32'(eq.size() > 0), 1);
                if (eq.size() > 0) chk("err_cycle", cyc, eq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, time %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int a;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 1);
        chk("rst_row_open", 32'(row_open), 0);
        chk("rst_dq_valid", 32'(dq_valid), 0);
        chk("rst_dqout", 32'(dqout), 0);
        chk("rst_err", 32'(err), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", 32'(cmd_ready), 1);
        issue(3'd3, 4'd0, 4'd0, 1'b1, a);
        chk("rd_idle_closed", 32'(row_open), 0);
        issue(3'd1, 4'd12, 4'd0, 1'b1, a);
        chk("act_bad_row_closed", 32'(row_open), 0);
        issue(3'd6, 4'd0, 4'd0, 1'b1, a);
        chk("illegal_code_closed", 32'(row_open), 0);
        issue(3'd2, 4'd0, 4'd0, 1'b0, a);
        chk("pre_idle_closed", 32'(row_open), 0);
        issue(3'd1, 4'd1, 4'd0, 1'b0, a);
        chk("act_row_open", 32'(row_open), 1);
        chk("act_no_err", 32'(err), 0);
        issue(3'd1, 4'd3, 4'd0, 1'b1, a);
        chk("act_active_open", 32'(row_open), 1);
        chk("act_active_ready", 32'(cmd_ready), 1);
        wr(4'd0, 32'h87654321);
`ifdef BANK_AUTOPRE_EN
        chk("autopre_wr_closed", 32'(row_open), 0);
        issue(3'd3, 4'd0, 4'd0, 1'b1, a);
        chk("autopre_rd_err_closed", 32'(row_open), 0);
        issue(3'd1, 4'd1, 4'd0, 1'b0, a);
        rd(4'd0, 32'h87654321, 8);
        chk("autopre_rd_closed", 32'(row_open), 0);
`else
        chk("wr_done_open", 32'(row_open), 1);
        chk("wr_done_ready", 32'(cmd_ready), 1);
        rd(4'd0, 32'h87654321, 8);
        chk("rd_done_ready", 32'(cmd_ready), 1);
        chk("rd_done_open", 32'(row_open), 1);
        rd(4'd5, 32'h54321876, 8);
        wr(4'd10, 32'h0FEDCBA9);
        rd(4'd8, 32'hEDCBA90F, 8);
        issue(3'd2, 4'd0, 4'd0, 1'b0, a);
        chk("pre_closes_row", 32'(row_open), 0);
        issue(3'd1, 4'd11, 4'd0, 1'b0, a);
        wr(4'd0, 32'h89ABCDEF);
        rd(4'd3, 32'hDEF89ABC, 8);
        issue(3'd2, 4'd0, 4'd0, 1'b0, a);
        issue(3'd1, 4'd1, 4'd0, 1'b0, a);
        rd(4'd0, 32'h87654321, 8);
        issue(3'd2, 4'd0, 4'd0, 1'b0, a);
`endif
        issue(3'd1, 4'd1, 4'd0, 1'b0, a);
        rd(4'd0, 32'h87654321, 3);
        rst_n = 1'b0;
        #1;
        chk("abort_dq_valid", 32'(dq_valid), 0);
        chk("abort_dqout", 32'(dqout), 0);
        chk("abort_row_open", 32'(row_open), 0);
        chk("abort_cmd_ready", 32'(cmd_ready), 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_abort", 32'(cmd_ready), 1);
        issue(3'd1, 4'd1, 4'd0, 1'b0, a);
        rd(4'd0, 32'h87654321, 8);
        chk("final_row_open", 32'(row_open), 32'(!AP));
        repeat (3) @(posedge clk);
        #1;
        chk("beats_left", bq.size(), 0);
        chk("errs_left", eq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
